uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-004 SHALL have port tx_data, input, 8, byte to transmit (LSB first).
REQ-005 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-006 SHALL have port tx_ready, output, 1, block can accept a byte.
REQ-007 SHALL have port divisor, input, DIV_W, clk cycles per serial bit.
REQ-008 SHALL have port data_bits, input, 2, word length: 0=5, 1=6, 2=7, 3=8 bits.
REQ-009 SHALL have port two_stop, input, 1, 1 = two stop bits.
REQ-010 SHALL have port parity_en, input, 1, parity bit enable.
REQ-011 SHALL have port parity_odd, input, 1, 1 = odd parity, 0 = even parity.
REQ-012 SHALL have port sdata, output, 1, serial line that drives serial_if.sdata; idle high.
REQ-013 SHALL have port busy, output, 1, frame in progress.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL assert tx_ready only in IDLE; a transfer occurs on a rising clk edge with tx_valid and tx_ready both high.
REQ-016 SHALL capture tx_data, divisor, data_bits, two_stop, parity_en and parity_odd at the transfer; later input changes SHALL NOT affect the current frame.
REQ-017 SHALL drive sdata low (START) from the cycle after the transfer, so start latency is 1 clk.
REQ-018 SHALL hold every bit for exactly max(divisor,1) clk cycles; divisor=0 SHALL behave as 1.
REQ-019 SHALL send data bits LSB first, 5 to 8 bits per data_bits; upper unused bits SHALL be ignored.
REQ-020 SHALL compute parity over the sent data bits only: even = XOR, odd = ~XOR.
REQ-021 SHALL skip PARITY when parity_en=0 and go DATA->STOP.
REQ-022 SHALL drive sdata high in STOP for 1 or 2 bit times, then return to IDLE.
REQ-023 SHALL assert tx_ready in the cycle after the last stop-bit cycle; a byte presented then SHALL start immediately, giving back-to-back frames with no extra idle bit.
REQ-024 SHALL assert busy in all states except IDLE; busy = ~tx_ready.
REQ-025 SHALL register sdata so that it is glitch-free.

Reset
REQ-026 SHALL force state=IDLE, sdata=1, busy=0, tx_ready=1, and clear the bit counter and divisor counter on any clk edge with rst_n=0.
REQ-027 SHALL abort a frame in progress if reset occurs mid-frame; sdata SHALL be high from the next edge and SHALL NOT emit a partial stop sequence.

Configuration
REQ-028 SHALL compile PARITY state and logic only when UART_TX_PARITY_EN is defined.
REQ-029 SHALL, when UART_TX_PARITY_EN is undefined, ignore parity_en and parity_odd; frames SHALL never include a parity bit.

Structure
REQ-030 SHALL place the FSM state enum type uart_tx_state_e and data-length decode constants in shared package uart_tx_pkg.
REQ-031 SHALL use one sub-module, uart_baud_counter, which generates a one-cycle bit_tick every max(divisor,1) cycles and restarts on frame start.

Verification
REQ-032 SHALL cover: divisor=4, 8N1, byte 0xA5 -> sdata = 0,1,0,1,0,0,1,0,1,1, each level held 4 clk; tx_ready high again 40 clk after the transfer.
REQ-033 SHALL cover: divisor=2, 7 data bits, even parity, two_stop, byte 0xFF -> 7 ones, parity 1, two stop bits; bits 0-7 of data ignored beyond bit 6.
REQ-034 SHALL cover: divisor=0, 5 data bits, odd parity, byte 0x03 -> each bit 1 clk; parity bit 1; frame 8 clk long.
REQ-035 SHALL cover: tx_valid held high with 0x11 then 0x22, divisor=3, 8N1 -> second start bit immediately after first stop bit, no idle gap.
REQ-036 SHALL cover: rst_n low for 1 clk during the 3rd data bit -> sdata=1, tx_ready=1 next cycle, and the next byte is sent as a clean frame.
REQ-037 SHALL cover: change divisor from 4 to 8 mid-frame -> current frame keeps 4-clk bits and the next frame uses 8.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter types: FSM state encoding and word-length decode helpers.
// Latency: n/a (types and pure functions). Backpressure: n/a. Optional parity state via UART_TX_PARITY_EN.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_e;

    localparam logic [2:0] LAST_IDX_5 = 3'd4;
    localparam logic [2:0] LAST_IDX_6 = 3'd5;
    localparam logic [2:0] LAST_IDX_7 = 3'd6;
    localparam logic [2:0] LAST_IDX_8 = 3'd7;

    // Index of the final data bit sent for a data_bits code (0=5 .. 3=8 bits).
    function automatic logic [2:0] data_last_idx(input logic [1:0] data_bits);
        logic [2:0] idx;
        case (data_bits)
            2'd0:    idx = LAST_IDX_5;
            2'd1:    idx = LAST_IDX_6;
            2'd2:    idx = LAST_IDX_7;
            default: idx = LAST_IDX_8;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
        logic [7:0] m;
        case (data_bits)
            2'd0:    m = 8'h1F;
            2'd1:    m = 8'h3F;
            2'd2:    m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time generator: one-cycle bit_tick every max(divisor,1) clk while run is high.
// Latency: first tick max(divisor,1) cycles after restart. Backpressure: none; free-running while run.
module uart_baud_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor,
    input  logic             run,
    input  logic             restart,
    output logic             bit_tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] top_val;

    // A zero divisor is treated as one: tick on every cycle.
    assign top_val  = (divisor == '0) ? '0 : divisor - {{(DIV_W-1){1'b0}}, 1'b1};
    assign bit_tick = run && !restart && (cnt == top_val);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !run || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART byte serializer (start, 5-8 data LSB first, optional parity under UART_TX_PARITY_EN, 1-2 stop).
// Latency: start bit on sdata 1 clk after transfer; ready again 1 clk after last stop cycle. Backpressure: tx_ready low while busy.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       data_bits,
    input  logic             two_stop,
    input  logic             parity_en,
    input  logic             parity_odd,
    output logic             sdata,
    output logic             busy
);

    uart_tx_state_e   state;
    logic [7:0]       data_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       last_q;
    logic             two_stop_q;
    logic             second_q;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_nxt;
    logic             sdata_q;
    logic             ready_q;
    logic             transfer;
    logic             bit_tick;

`ifdef UART_TX_PARITY_EN
    logic par_on_q;
    logic par_bit_q;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

    assign transfer = tx_valid && ready_q;
    assign bit_nxt  = bit_cnt + 3'd1;
    assign tx_ready = ready_q;
    assign busy     = ~ready_q;
    assign sdata    = sdata_q;

    uart_baud_counter #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .divisor  (div_q),
        .run      (~ready_q),
        .restart  (transfer),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sdata_q    <= 1'b1;
            ready_q    <= 1'b1;
            bit_cnt    <= '0;
            second_q   <= 1'b0;
            data_q     <= '0;
            div_q      <= '0;
            last_q     <= '0;
            two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_on_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sdata_q <= 1'b1;
                    if (transfer) begin
                        data_q     <= tx_data;
                        div_q      <= divisor;
                        last_q     <= data_last_idx(data_bits);
                        two_stop_q <= two_stop;
`ifdef UART_TX_PARITY_EN
                        par_on_q   <= parity_en;
                        // Parity covers only the bits actually sent.
                        par_bit_q  <= (^(tx_data & data_mask(data_bits))) ^ parity_odd;
`endif
                        bit_cnt    <= '0;
                        second_q   <= 1'b0;
                        sdata_q    <= 1'b0;
                        ready_q    <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        sdata_q <= data_q[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == last_q) begin
`ifdef UART_TX_PARITY_EN
                            if (par_on_q) begin
                                sdata_q <= par_bit_q;
                                state   <= PARITY;
                            end else begin
                                sdata_q <= 1'b1;
                                state   <= STOP;
                            end
`else
                            sdata_q <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_nxt;
                            sdata_q <= data_q[bit_nxt];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        sdata_q <= 1'b1;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    sdata_q <= 1'b1;
                    if (bit_tick) begin
                        if (two_stop_q && !second_q) begin
                            second_q <= 1'b1;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    sdata_q <= 1'b1;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboarded bench for uart_tx_serializer: stimulus pushes expected frames, a monitor checks sdata cycle by cycle.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    typedef struct {
        logic [11:0] lv;
        int          nb;
        int          d;
        int          start;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] divisor = '0;
    logic [1:0]  data_bits = '0;
    logic        two_stop = 1'b0;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        sdata;
    logic        busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    frame_t exp_q[$];
    frame_t cur;
    bit     in_frame = 1'b0;
    int     idx = 0;

    uart_tx_serializer #(.DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .divisor    (divisor),
        .data_bits  (data_bits),
        .two_stop   (two_stop),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .sdata      (sdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference frame: line levels per bit time, built from the framing rules.
    function automatic frame_t model(input logic [7:0] b, input logic [15:0] dv, input logic [1:0] db,
                                     input logic ts, input logic pe, input logic po);
        frame_t f;
        int n;
        int ones;
        f.lv = '0;
        f.nb = 0;
        f.start = 0;
        n = 5 + int'(db);
        ones = 0;
        f.lv[f.nb] = 1'b0; f.nb++;
        for (int i = 0; i < n; i++) begin
            f.lv[f.nb] = b[i]; f.nb++;
            if (b[i]) ones++;
        end
        if (pe && PAR_BUILT) begin
            f.lv[f.nb] = po ? ((ones % 2) == 0) : ((ones % 2) == 1); f.nb++;
        end
        f.lv[f.nb] = 1'b1; f.nb++;
        if (ts) begin
            f.lv[f.nb] = 1'b1; f.nb++;
        end
        f.d = (dv == 0) ? 1 : int'(dv);
        return f;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~tx_ready});
            if (!rst_n) begin
                in_frame = 1'b0;
                exp_q.delete();
            end else if (in_frame) begin
                if (idx < cur.nb * cur.d) begin
                    chk("sdata_bit", {31'd0, sdata}, {31'd0, cur.lv[idx / cur.d]});
                    idx++;
                end else begin
                    chk("end_ready", {31'd0, tx_ready}, 32'd1);
                    chk("end_sdata", {31'd0, sdata}, 32'd1);
                    in_frame = 1'b0;
                end
            end else if (sdata == 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("start_latency", cyc, cur.start);
                    idx = 1;
                    in_frame = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [15:0] dv, input logic [1:0] db,
                        input logic ts, input logic pe, input logic po, input bit keep);
        frame_t f;
        int n;
        bit ok;
        tx_data = b; divisor = dv; data_bits = db;
        two_stop = ts; parity_en = pe; parity_odd = po;
        tx_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
            end else begin
                n++;
                if (n > 5000) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    break;
                end
                @(posedge clk); #1;
            end
        end
        if (ok) begin
            f = model(b, dv, db, ts, pe, po);
            f.start = cyc + 1;
            exp_q.push_back(f);
            @(posedge clk); #1;
        end
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 || in_frame) begin
            @(posedge clk); #1;
            n++;
            if (n > 5000) begin
                chk("drain_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sdata", {31'd0, sdata}, 32'd1);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        send(8'hA5, 16'd4, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(8'hFF, 16'd2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle();
        send(8'h03, 16'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle();
        send(8'h11, 16'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h22, 16'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Reset pulse landing in the third data bit (cycles 12..15 of a divisor-4 frame).
        send(8'h5A, 16'd4, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_sdata", {31'd0, sdata}, 32'd1);
        chk("abort_ready", {31'd0, tx_ready}, 32'd1);
        @(posedge clk); #1;
        send(8'h96, 16'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Inputs scrambled mid-frame must not disturb the captured configuration.
        send(8'h3C, 16'd4, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        divisor = 16'd8; tx_data = 8'hC3; data_bits = 2'd0; two_stop = 1'b1; parity_en = 1'b1;
        send(8'hC3, 16'd8, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            logic [7:0]  rb;
            logic [15:0] rd;
            bit          rk;
            rb = 8'($urandom);
            rd = 16'($urandom_range(0, 5));
            rk = (i != 39) && ($urandom_range(0, 1) == 1);
            send(rb, rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rk);
            if (!rk) repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
